// File: rtl/svc_sram_rw_arb.sv
// svc_sram_rw_arb: round-robin arbiter sharing one SRAM command port between the read and write front-ends.
// Define SVC_SRAM_RW_ARB_BURST_LOCK_EN to hold a grant for a whole burst (released when the last beat is accepted).
module svc_sram_rw_arb #(
    parameter int SRAM_ADDR_WIDTH = 16,
    parameter int SRAM_DATA_WIDTH = 16,
    parameter int SRAM_META_WIDTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         rd_cmd_valid,
    output logic                         rd_cmd_ready,
    input  logic [SRAM_ADDR_WIDTH-1:0]   rd_cmd_addr,
    input  logic [SRAM_META_WIDTH-1:0]   rd_cmd_meta,
    input  logic                         rd_cmd_last,
    input  logic                         wr_cmd_valid,
    output logic                         wr_cmd_ready,
    input  logic [SRAM_ADDR_WIDTH-1:0]   wr_cmd_addr,
    input  logic [SRAM_META_WIDTH-1:0]   wr_cmd_meta,
    input  logic [SRAM_DATA_WIDTH-1:0]   wr_cmd_data,
    input  logic [SRAM_DATA_WIDTH/8-1:0] wr_cmd_strb,
    input  logic                         wr_cmd_last,
    output logic                         sram_cmd_valid,
    input  logic                         sram_cmd_ready,
    output logic                         sram_cmd_wr_en,
    output logic [SRAM_ADDR_WIDTH-1:0]   sram_cmd_addr,
    output logic [SRAM_META_WIDTH-1:0]   sram_cmd_meta,
    output logic [SRAM_DATA_WIDTH-1:0]   sram_cmd_data,
    output logic [SRAM_DATA_WIDTH/8-1:0] sram_cmd_strb,
    output logic                         sram_cmd_last
);

`ifdef SVC_SRAM_RW_ARB_BURST_LOCK_EN
    localparam bit BURST_LOCK = 1'b1;
`else
    localparam bit BURST_LOCK = 1'b0;
`endif

    typedef enum logic [1:0] {IDLE, GNT_RD, GNT_WR} state_t;

    state_t state, state_nxt;
    logic   rr_wr, rr_wr_nxt;           // 0: read side wins a tie, 1: write side wins
    logic   burst_open, burst_open_nxt;
    logic   out_free;
    logic   rd_fire, wr_fire;
    logic   rd_done, wr_done;

    assign out_free = !sram_cmd_valid || sram_cmd_ready;
    assign rd_fire  = rd_cmd_valid && rd_cmd_ready;
    assign wr_fire  = wr_cmd_valid && wr_cmd_ready;
    // A grant ends after every beat, or only after the last beat when bursts are locked.
    assign rd_done  = rd_fire && (!BURST_LOCK || rd_cmd_last);
    assign wr_done  = wr_fire && (!BURST_LOCK || wr_cmd_last);

    always_comb begin
        state_nxt      = state;
        rr_wr_nxt      = rr_wr;
        burst_open_nxt = burst_open;
        rd_cmd_ready   = 1'b0;
        wr_cmd_ready   = 1'b0;
        case (state)
            IDLE: begin
                if (rd_cmd_valid && (!wr_cmd_valid || !rr_wr)) begin
                    state_nxt = GNT_RD;
                end else if (wr_cmd_valid) begin
                    state_nxt = GNT_WR;
                end
            end
            GNT_RD: begin
                rd_cmd_ready = out_free;
                if (rd_fire) begin
                    burst_open_nxt = BURST_LOCK && !rd_cmd_last;
                end
                if (rd_done) begin
                    rr_wr_nxt = 1'b1;
                    state_nxt = wr_cmd_valid ? GNT_WR : (rd_cmd_valid ? GNT_RD : IDLE);
                end else if (!rd_cmd_valid && !burst_open) begin
                    // Requester went quiet between bursts: release the port.
                    state_nxt = wr_cmd_valid ? GNT_WR : IDLE;
                end
            end
            GNT_WR: begin
                wr_cmd_ready = out_free;
                if (wr_fire) begin
                    burst_open_nxt = BURST_LOCK && !wr_cmd_last;
                end
                if (wr_done) begin
                    rr_wr_nxt = 1'b0;
                    state_nxt = rd_cmd_valid ? GNT_RD : (wr_cmd_valid ? GNT_WR : IDLE);
                end else if (!wr_cmd_valid && !burst_open) begin
                    state_nxt = rd_cmd_valid ? GNT_RD : IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            rr_wr      <= 1'b0;
            burst_open <= 1'b0;
        end else begin
            state      <= state_nxt;
            rr_wr      <= rr_wr_nxt;
            burst_open <= burst_open_nxt;
        end
    end

    // Output stage: loads only when free, so a stalled beat is held untouched.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sram_cmd_valid <= 1'b0;
            sram_cmd_wr_en <= 1'b0;
            sram_cmd_addr  <= '0;
            sram_cmd_meta  <= '0;
            sram_cmd_data  <= '0;
            sram_cmd_strb  <= '0;
            sram_cmd_last  <= 1'b0;
        end else if (rd_fire) begin
            sram_cmd_valid <= 1'b1;
            sram_cmd_wr_en <= 1'b0;
            sram_cmd_addr  <= rd_cmd_addr;
            sram_cmd_meta  <= rd_cmd_meta;
            sram_cmd_data  <= '0;
            sram_cmd_strb  <= '0;
            sram_cmd_last  <= rd_cmd_last;
        end else if (wr_fire) begin
            sram_cmd_valid <= 1'b1;
            sram_cmd_wr_en <= 1'b1;
            sram_cmd_addr  <= wr_cmd_addr;
            sram_cmd_meta  <= wr_cmd_meta;
            sram_cmd_data  <= wr_cmd_data;
            sram_cmd_strb  <= wr_cmd_strb;
            sram_cmd_last  <= wr_cmd_last;
        end else if (sram_cmd_ready) begin
            sram_cmd_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_svc_sram_rw_arb.sv
// tb_svc_sram_rw_arb: directed and randomized checks of svc_sram_rw_arb against a queue-based reference model.
// Honours SVC_SRAM_RW_ARB_BURST_LOCK_EN for the arbitration-order expectations.
module tb_svc_sram_rw_arb;
    localparam int AW = 16;
    localparam int DW = 16;
    localparam int MW = 4;
    localparam int SW = DW / 8;
`ifdef SVC_SRAM_RW_ARB_BURST_LOCK_EN
    localparam bit LOCK = 1'b1;
`else
    localparam bit LOCK = 1'b0;
`endif

    typedef struct packed {
        logic          wr;
        logic [AW-1:0] addr;
        logic [MW-1:0] meta;
        logic [DW-1:0] data;
        logic [SW-1:0] strb;
        logic          last;
    } beat_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          rd_cmd_valid, rd_cmd_ready, rd_cmd_last;
    logic [AW-1:0] rd_cmd_addr;
    logic [MW-1:0] rd_cmd_meta;
    logic          wr_cmd_valid, wr_cmd_ready, wr_cmd_last;
    logic [AW-1:0] wr_cmd_addr;
    logic [MW-1:0] wr_cmd_meta;
    logic [DW-1:0] wr_cmd_data;
    logic [SW-1:0] wr_cmd_strb;
    logic          sram_cmd_valid, sram_cmd_ready, sram_cmd_wr_en, sram_cmd_last;
    logic [AW-1:0] sram_cmd_addr;
    logic [MW-1:0] sram_cmd_meta;
    logic [DW-1:0] sram_cmd_data;
    logic [SW-1:0] sram_cmd_strb;

    int    vectors = 0;
    int    miscompares = 0;
    int    cyc = 0;
    int    rd_gap = 0, wr_gap = 0, rdy_pct = 100;
    int    must_next = -1;
    beat_t rd_q[$], wr_q[$], out_q[$], seen[$];
    int    seen_cyc[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    svc_sram_rw_arb #(.SRAM_ADDR_WIDTH(AW), .SRAM_DATA_WIDTH(DW), .SRAM_META_WIDTH(MW)) dut (
        .clk(clk), .rst(rst),
        .rd_cmd_valid(rd_cmd_valid), .rd_cmd_ready(rd_cmd_ready), .rd_cmd_addr(rd_cmd_addr),
        .rd_cmd_meta(rd_cmd_meta), .rd_cmd_last(rd_cmd_last),
        .wr_cmd_valid(wr_cmd_valid), .wr_cmd_ready(wr_cmd_ready), .wr_cmd_addr(wr_cmd_addr),
        .wr_cmd_meta(wr_cmd_meta), .wr_cmd_data(wr_cmd_data), .wr_cmd_strb(wr_cmd_strb),
        .wr_cmd_last(wr_cmd_last),
        .sram_cmd_valid(sram_cmd_valid), .sram_cmd_ready(sram_cmd_ready), .sram_cmd_wr_en(sram_cmd_wr_en),
        .sram_cmd_addr(sram_cmd_addr), .sram_cmd_meta(sram_cmd_meta), .sram_cmd_data(sram_cmd_data),
        .sram_cmd_strb(sram_cmd_strb), .sram_cmd_last(sram_cmd_last)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic beat_t mk_beat(input logic wr, input int addr, input int meta, input int data,
                                      input int strb, input logic last);
        beat_t b;
        b.wr   = wr;
        b.addr = AW'(addr);
        b.meta = MW'(meta);
        b.data = wr ? DW'(data) : '0;
        b.strb = wr ? SW'(strb) : '0;
        b.last = last;
        return b;
    endfunction

    // Upstream drivers obey the AXI rule: valid stays up with stable fields until accepted.
    task automatic drive();
        if (!rd_cmd_valid && rd_q.size() > 0 && $urandom_range(99) >= rd_gap) begin
            rd_cmd_valid = 1'b1;
            rd_cmd_addr  = rd_q[0].addr;
            rd_cmd_meta  = rd_q[0].meta;
            rd_cmd_last  = rd_q[0].last;
        end
        if (!wr_cmd_valid && wr_q.size() > 0 && $urandom_range(99) >= wr_gap) begin
            wr_cmd_valid = 1'b1;
            wr_cmd_addr  = wr_q[0].addr;
            wr_cmd_meta  = wr_q[0].meta;
            wr_cmd_data  = wr_q[0].data;
            wr_cmd_strb  = wr_q[0].strb;
            wr_cmd_last  = wr_q[0].last;
        end
        sram_cmd_ready = ($urandom_range(99) < rdy_pct);
    endtask

    // One clock: sample and check at negedge, then retire handshakes and drive after posedge.
    task automatic step();
        logic  rd_hs, wr_hs, s_hs, other_v, beat_last;
        int    side;
        beat_t got;
        @(negedge clk);
        rd_hs = rd_cmd_valid && rd_cmd_ready;
        wr_hs = wr_cmd_valid && wr_cmd_ready;
        s_hs  = sram_cmd_valid && sram_cmd_ready;
        got   = '{sram_cmd_wr_en, sram_cmd_addr, sram_cmd_meta, sram_cmd_data, sram_cmd_strb, sram_cmd_last};
        chk("ready_excl", 64'(rd_cmd_ready && wr_cmd_ready), 64'(0));
        chk("out_valid", 64'(sram_cmd_valid), 64'(out_q.size() > 0));
        if (sram_cmd_valid && out_q.size() > 0) chk("out_beat", 64'(got), 64'(out_q[0]));
        if (s_hs) begin
            seen.push_back(got);
            seen_cyc.push_back(cyc);
        end
        if (rd_hs || wr_hs) begin
            side      = rd_hs ? 0 : 1;
            other_v   = rd_hs ? wr_cmd_valid : rd_cmd_valid;
            beat_last = rd_hs ? rd_cmd_last : wr_cmd_last;
            if (must_next >= 0) chk("arb_order", 64'(side), 64'(must_next));
            if (LOCK && !beat_last) must_next = side;
            else if (other_v)       must_next = 1 - side;
            else                    must_next = -1;
        end
        @(posedge clk);
        #1;
        if (s_hs && out_q.size() > 0) void'(out_q.pop_front());
        if (rd_hs) begin
            out_q.push_back(rd_q.pop_front());
            rd_cmd_valid = 1'b0;
        end
        if (wr_hs) begin
            out_q.push_back(wr_q.pop_front());
            wr_cmd_valid = 1'b0;
        end
        drive();
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        rd_cmd_valid = 1'b0;
        wr_cmd_valid = 1'b0;
        sram_cmd_ready = 1'b0;
        rd_q.delete(); wr_q.delete(); out_q.delete(); seen.delete(); seen_cyc.delete();
        must_next = -1;
        rd_gap = 0; wr_gap = 0; rdy_pct = 100;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic drain(input string tag, input int max_cycles);
        int n = 0;
        while ((rd_q.size() + wr_q.size() + out_q.size()) > 0 && n < max_cycles) begin
            step();
            n++;
        end
        chk(tag, 64'((rd_q.size() + wr_q.size() + out_q.size()) == 0), 64'(1));
    endtask

    initial begin
        logic exp_wr [6];
        int   n;
        beat_t b;
        rst = 1'b1;
        rd_cmd_valid = 0; rd_cmd_addr = '0; rd_cmd_meta = '0; rd_cmd_last = 0;
        wr_cmd_valid = 0; wr_cmd_addr = '0; wr_cmd_meta = '0; wr_cmd_data = '0; wr_cmd_strb = '0; wr_cmd_last = 0;
        sram_cmd_ready = 0;
        #2;
        chk("rst_sram_valid", 64'(sram_cmd_valid), 64'(0));
        chk("rst_rd_ready", 64'(rd_cmd_ready), 64'(0));
        chk("rst_wr_ready", 64'(wr_cmd_ready), 64'(0));
        chk("rst_addr", 64'(sram_cmd_addr), 64'(0));
        chk("rst_data", 64'(sram_cmd_data), 64'(0));

        // Read-only burst 0x10..0x13
        do_reset();
        for (int i = 0; i < 4; i++) rd_q.push_back(mk_beat(1'b0, 'h10 + i, i, 0, 0, i == 3));
        drive();
        drain("rd_burst_drain", 30);
        chk("rd_burst_count", 64'(seen.size()), 64'(4));
        for (int i = 0; i < seen.size() && i < 4; i++) begin
            chk("rd_burst_wr_en", 64'(seen[i].wr), 64'(0));
            chk("rd_burst_addr", 64'(seen[i].addr), 64'('h10 + i));
            chk("rd_burst_last", 64'(seen[i].last), 64'(i == 3));
        end

        // Contention: 4-beat read and 2-beat write both valid at reset release
        do_reset();
        for (int i = 0; i < 4; i++) rd_q.push_back(mk_beat(1'b0, 'h20 + i, 1, 0, 0, i == 3));
        for (int i = 0; i < 2; i++) wr_q.push_back(mk_beat(1'b1, 'h40 + i, 2, 'hA5A0 + i, 3, i == 1));
        if (LOCK) exp_wr = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        else      exp_wr = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        drive();
        drain("cont_drain", 40);
        chk("cont_count", 64'(seen.size()), 64'(6));
        for (int i = 0; i < seen.size() && i < 6; i++) begin
            chk("cont_order", 64'(seen[i].wr), 64'(exp_wr[i]));
            chk("cont_no_bubble", 64'(seen_cyc[i] - seen_cyc[0]), 64'(i));
        end

        // Back-pressure on a single write beat
        do_reset();
        wr_q.push_back(mk_beat(1'b1, 'h55, 7, 'hBEEF, 3, 1'b1));
        rdy_pct = 0;
        drive();
        n = 0;
        while (!sram_cmd_valid && n < 10) begin
            step();
            n++;
        end
        chk("bp_out_seen", 64'(sram_cmd_valid), 64'(1));
        repeat (3) begin
            chk("bp_valid", 64'(sram_cmd_valid), 64'(1));
            chk("bp_data", 64'(sram_cmd_data), 64'('hBEEF));
            chk("bp_strb", 64'(sram_cmd_strb), 64'(3));
            chk("bp_wr_en", 64'(sram_cmd_wr_en), 64'(1));
            chk("bp_addr", 64'(sram_cmd_addr), 64'('h55));
            step();
        end
        chk("bp_none_taken", 64'(seen.size()), 64'(0));
        rdy_pct = 100;
        drain("bp_drain", 10);
        repeat (2) step();
        chk("bp_one_write", 64'(seen.size()), 64'(1));
        if (seen.size() > 0) chk("bp_final_data", 64'(seen[0].data), 64'('hBEEF));

        // Fairness: back-to-back single-beat commands on both sides
        do_reset();
        for (int i = 0; i < 10; i++) begin
            rd_q.push_back(mk_beat(1'b0, 'h100 + i, 3, 0, 0, 1'b1));
            wr_q.push_back(mk_beat(1'b1, 'h200 + i, 4, 'h1234 + i, 1, 1'b1));
        end
        drive();
        drain("fair_drain", 80);
        chk("fair_count", 64'(seen.size()), 64'(20));
        n = 0;
        for (int i = 0; i < seen.size(); i++) begin
            chk("fair_alternate", 64'(seen[i].wr), 64'(i % 2));
            if (seen[i].wr) n++;
        end
        chk("fair_writes", 64'(n), 64'(10));

        // Asynchronous reset in the middle of a read burst
        do_reset();
        for (int i = 0; i < 8; i++) rd_q.push_back(mk_beat(1'b0, 'h300 + i, 5, 0, 0, i == 7));
        drive();
        repeat (3) step();
        chk("mid_rd_ready", 64'(rd_cmd_ready), 64'(1));
        chk("mid_sram_valid", 64'(sram_cmd_valid), 64'(1));
        #3;
        rst = 1'b1;
        #1;
        chk("async_rst_valid", 64'(sram_cmd_valid), 64'(0));
        chk("async_rst_rd_ready", 64'(rd_cmd_ready), 64'(0));
        chk("async_rst_wr_ready", 64'(wr_cmd_ready), 64'(0));

        // Randomized bursts, gaps and back-pressure
        do_reset();
        rd_gap = 30; wr_gap = 30; rdy_pct = 70;
        for (int k = 0; k < 60; k++) begin
            n = $urandom_range(4, 1);
            for (int i = 0; i < n; i++) begin
                b = mk_beat($urandom_range(1), $urandom, $urandom, $urandom, $urandom, i == n - 1);
                if (b.wr) wr_q.push_back(b);
                else      rd_q.push_back(b);
            end
        end
        drive();
        drain("rand_drain", 3000);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "simulation did not complete");
    end

endmodule
